lsu: RTL and testbench

// - Memory-stage load/store unit. Consumes the execute stage's registered memory request
//   (ieu_mem_ren/wen, ieu_mem_addr, ieu_store_data, ieu_func3) and runs the data-memory handshake.
// - Aligns and sign/zero-extends load data, then feeds result and regfile write controls to writeback.
// - Drives ldst_stall upstream while an access is outstanding.

---
 rtl/brq_lsu_pkg.sv | 34 +++
 rtl/lsu_align.sv | 40 ++++
 rtl/lsu.sv | 189 ++++++++++++++++++
 tb/tb_lsu.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brq_lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// Access size is carried in func3[1:0]; func3[2] selects zero-extension on loads.
package brq_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte offset rounded down to the natural alignment of the access size.
    function automatic logic [1:0] align_off(input logic [2:0] func3, input logic [1:0] off);
        case (func3[1:0])
            F3_B[1:0]: return off;
            F3_H[1:0]: return {off[1], 1'b0};
            default:   return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] be_gen(input logic [2:0] func3, input logic [1:0] off);
        case (func3[1:0])
            F3_B[1:0]: return 4'b0001 << off;
            F3_H[1:0]: return 4'b0011 << off;
            default:   return 4'hF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: replicates store data across byte lanes and
// shifts/extends a returned load word into a register value.
module lsu_align
    import brq_lsu_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input  logic [2:0]           st_func3_i,
    input  logic [DataWidth-1:0] st_data_i,
    output logic [DataWidth-1:0] st_wdata_o,
    input  logic [2:0]           ld_func3_i,
    input  logic [1:0]           ld_off_i,
    input  logic [DataWidth-1:0] ld_rdata_i,
    output logic [DataWidth-1:0] ld_data_o
);

    logic [DataWidth-1:0] shifted;

    always_comb begin
        st_wdata_o = st_data_i;
        if (st_func3_i[1:0] == F3_B[1:0]) begin
            st_wdata_o = {(DataWidth/8){st_data_i[7:0]}};
        end else if (st_func3_i[1:0] == F3_H[1:0]) begin
            st_wdata_o = {(DataWidth/16){st_data_i[15:0]}};
        end
    end

    assign shifted = ld_rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        case (ld_func3_i)
            F3_B:    ld_data_o = {{(DataWidth-8){shifted[7]}}, shifted[7:0]};
            F3_BU:   ld_data_o = {{(DataWidth-8){1'b0}}, shifted[7:0]};
            F3_H:    ld_data_o = {{(DataWidth-16){shifted[15]}}, shifted[15:0]};
            F3_HU:   ld_data_o = {{(DataWidth-16){1'b0}}, shifted[15:0]};
            default: ld_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Memory-stage load/store unit: runs the dmem req/gnt/rvalid handshake and feeds writeback.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of aligning them down.
module lsu
    import brq_lsu_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int AddrWidth    = 10,
    parameter int RegAddrWidth = 5
) (
    input  logic                    brq_clk,
    input  logic                    brq_rst,
    input  logic                    ieu_mem_ren,
    input  logic                    ieu_mem_wen,
    input  logic                    ieu_memtoreg,
    input  logic                    ieu_regfile_en,
    input  logic [RegAddrWidth-1:0] ieu_addr_dst,
    input  logic [2:0]              ieu_func3,
    input  logic [DataWidth-1:0]    ieu_mem_addr,
    input  logic [DataWidth-1:0]    ieu_store_data,
    input  logic [DataWidth-1:0]    ieu_alu_result_dealy,
    output logic                    dmem_req,
    input  logic                    dmem_gnt,
    output logic                    dmem_we,
    output logic [3:0]              dmem_be,
    output logic [AddrWidth-1:0]    dmem_addr,
    output logic [DataWidth-1:0]    dmem_wdata,
    input  logic                    dmem_rvalid,
    input  logic [DataWidth-1:0]    dmem_rdata,
    output logic                    ldst_stall,
    output logic                    ldst_regfile_en,
    output logic                    ldst_memtoreg,
    output logic [RegAddrWidth-1:0] ldst_addr_dst,
    output logic [DataWidth-1:0]    ldst_mem_result,
    output logic [DataWidth-1:0]    ldst_alu_result,
    output logic                    ldst_misalign
);

    lsu_state_e            state_q;
    logic                  req_q;
    logic                  we_q;
    logic [3:0]            be_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [DataWidth-1:0]  wdata_q;
    logic [2:0]            ldFunc3_q;
    logic [1:0]            ldOff_q;

    logic                    regfileEn_q, regfileEn_d;
    logic [DataWidth-1:0]    memResult_q, memResult_d;
    logic                    memtoreg_q;
    logic [RegAddrWidth-1:0] addrDst_q;
    logic [DataWidth-1:0]    aluResult_q;

    logic                 memOp;
    logic                 misalign;
    logic                 start;
    logic                 loadDone;
    logic [1:0]           effOff;
    logic [DataWidth-1:0] stWdata;
    logic [DataWidth-1:0] ldData;
    logic                 unusedAddrBits;

    assign memOp          = ieu_mem_ren | ieu_mem_wen;
    assign effOff         = align_off(ieu_func3, ieu_mem_addr[1:0]);
    assign unusedAddrBits = ^ieu_mem_addr[DataWidth-1:AddrWidth+2];

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    assign misalign = memOp &&
        ((ieu_func3[1:0] == F3_H[1:0] && ieu_mem_addr[0]) ||
         (ieu_func3[1:0] == F3_W[1:0] && ieu_mem_addr[1:0] != 2'b00));

    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state_q == IDLE) && misalign;
        end
    end

    assign ldst_misalign = misalign_q;
`else
    assign misalign      = 1'b0;
    assign ldst_misalign = 1'b0;
`endif

    assign start    = (state_q == IDLE) && memOp && !misalign;
    assign loadDone = (state_q == WAIT) && dmem_rvalid;

    lsu_align #(.DataWidth(DataWidth)) u_align (
        .st_func3_i (ieu_func3),
        .st_data_i  (ieu_store_data),
        .st_wdata_o (stWdata),
        .ld_func3_i (ldFunc3_q),
        .ld_off_i   (ldOff_q),
        .ld_rdata_i (dmem_rdata),
        .ld_data_o  (ldData)
    );

    // The request is latched on leaving IDLE so the bus stays stable until gnt; a load wins over a store.
    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ldFunc3_q <= '0;
            ldOff_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= REQ;
                        req_q     <= 1'b1;
                        we_q      <= !ieu_mem_ren;
                        be_q      <= be_gen(ieu_func3, effOff);
                        addr_q    <= ieu_mem_addr[AddrWidth+1:2];
                        wdata_q   <= stWdata;
                        ldFunc3_q <= ieu_func3;
                        ldOff_q   <= effOff;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        req_q   <= 1'b0;
                        state_q <= we_q ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ldst_stall = !brq_rst &&
        (start ||
         (state_q == REQ  && !(dmem_gnt && we_q)) ||
         (state_q == WAIT && !dmem_rvalid));

    // Writeback only fires for idle-cycle ALU ops or on load completion; stores never write.
    always_comb begin
        regfileEn_d = 1'b0;
        memResult_d = memResult_q;
        if (state_q == IDLE && !memOp) begin
            regfileEn_d = ieu_regfile_en;
        end
        if (loadDone) begin
            regfileEn_d = ieu_regfile_en;
            memResult_d = ldData;
        end
    end

    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            regfileEn_q <= 1'b0;
            memResult_q <= '0;
            memtoreg_q  <= 1'b0;
            addrDst_q   <= '0;
            aluResult_q <= '0;
        end else begin
            regfileEn_q <= regfileEn_d;
            memResult_q <= memResult_d;
            memtoreg_q  <= ieu_memtoreg;
            addrDst_q   <= ieu_addr_dst;
            aluResult_q <= ieu_alu_result_dealy;
        end
    end

    assign dmem_req        = req_q;
    assign dmem_we         = we_q;
    assign dmem_be         = be_q;
    assign dmem_addr       = addr_q;
    assign dmem_wdata      = wdata_q;
    assign ldst_regfile_en = regfileEn_q;
    assign ldst_memtoreg   = memtoreg_q;
    assign ldst_addr_dst   = addrDst_q;
    assign ldst_mem_result = memResult_q;
    assign ldst_alu_result = aluResult_q;

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed scenarios plus randomized loads/stores against an arithmetic model.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_lsu;

    logic        clk = 1'b0;
    logic        brq_rst;
    logic        ieu_mem_ren, ieu_mem_wen, ieu_memtoreg, ieu_regfile_en;
    logic [4:0]  ieu_addr_dst;
    logic [2:0]  ieu_func3;
    logic [31:0] ieu_mem_addr, ieu_store_data, ieu_alu_result_dealy;
    logic        dmem_req, dmem_gnt, dmem_we, dmem_rvalid;
    logic [3:0]  dmem_be;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        ldst_stall, ldst_regfile_en, ldst_memtoreg, ldst_misalign;
    logic [4:0]  ldst_addr_dst;
    logic [31:0] ldst_mem_result, ldst_alu_result;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu dut (
        .brq_clk              (clk),
        .brq_rst              (brq_rst),
        .ieu_mem_ren          (ieu_mem_ren),
        .ieu_mem_wen          (ieu_mem_wen),
        .ieu_memtoreg         (ieu_memtoreg),
        .ieu_regfile_en       (ieu_regfile_en),
        .ieu_addr_dst         (ieu_addr_dst),
        .ieu_func3            (ieu_func3),
        .ieu_mem_addr         (ieu_mem_addr),
        .ieu_store_data       (ieu_store_data),
        .ieu_alu_result_dealy (ieu_alu_result_dealy),
        .dmem_req             (dmem_req),
        .dmem_gnt             (dmem_gnt),
        .dmem_we              (dmem_we),
        .dmem_be              (dmem_be),
        .dmem_addr            (dmem_addr),
        .dmem_wdata           (dmem_wdata),
        .dmem_rvalid          (dmem_rvalid),
        .dmem_rdata           (dmem_rdata),
        .ldst_stall           (ldst_stall),
        .ldst_regfile_en      (ldst_regfile_en),
        .ldst_memtoreg        (ldst_memtoreg),
        .ldst_addr_dst        (ldst_addr_dst),
        .ldst_mem_result      (ldst_mem_result),
        .ldst_alu_result      (ldst_alu_result),
        .ldst_misalign        (ldst_misalign)
    );

    typedef struct {
        int          stallCycles;
        int          reqCycles;
        logic        reqEver;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [9:0]  addr;
        logic        we;
        logic        held;
        logic        timedOut;
        logic        regEn;
        logic        memtoreg;
        logic [4:0]  dst;
        logic [31:0] memResult;
        logic        misalign;
    } obs_t;

    // Reference model: plain arithmetic on sizes and byte offsets.
    function automatic int sizeOf(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic int offOf(input logic [2:0] f3, input logic [31:0] addr);
        int a;
        int sz;
        a  = int'(addr % 32'd4);
        sz = sizeOf(f3);
        return (a / sz) * sz;
    endfunction

    function automatic logic [3:0] expBe(input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = sizeOf(f3);
        if (sz == 4) return 4'hF;
        return 4'(((1 << sz) - 1) << offOf(f3, addr));
    endfunction

    function automatic logic [31:0] expWdata(input logic [2:0] f3, input logic [31:0] data);
        int sz;
        sz = sizeOf(f3);
        if (sz == 1) return (data % 32'd256) * 32'h01010101;
        if (sz == 2) return (data % 32'd65536) * 32'h00010001;
        return data;
    endfunction

    function automatic logic [31:0] expLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
        int          sz;
        logic [31:0] v;
        logic [31:0] span;
        sz = sizeOf(f3);
        if (sz == 4) return rdata;
        v    = rdata >> (8 * offOf(f3, addr));
        span = (sz == 1) ? 32'd256 : 32'd65536;
        v    = v % span;
        if ((f3 == 3'b000 || f3 == 3'b001) && v >= span / 2) v = v - span;
        return v;
    endfunction

    task automatic idleInputs();
        ieu_mem_ren          = 1'b0;
        ieu_mem_wen          = 1'b0;
        ieu_memtoreg         = 1'b0;
        ieu_regfile_en       = 1'b0;
        ieu_addr_dst         = '0;
        ieu_func3            = '0;
        ieu_mem_addr         = '0;
        ieu_store_data       = '0;
        ieu_alu_result_dealy = '0;
        dmem_gnt             = 1'b0;
        dmem_rvalid          = 1'b0;
    endtask

    // Drives one memory op through the handshake and records what the DUT showed; no judging here.
    task automatic runOp(input logic ren, input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] dst, input int gntDelay, input int rvDelay,
                         input logic [31:0] rdata, output obs_t o);
        logic granted;
        logic done;
        int   waitCnt;
        o = '{default: '0};
        o.held  = 1'b1;
        granted = 1'b0;
        done    = 1'b0;
        waitCnt = 0;
        @(posedge clk); #1;
        ieu_mem_ren          = ren;
        ieu_mem_wen          = wen;
        ieu_func3            = f3;
        ieu_mem_addr         = addr;
        ieu_store_data       = sdata;
        ieu_regfile_en       = 1'b1;
        ieu_memtoreg         = ren;
        ieu_addr_dst         = dst;
        ieu_alu_result_dealy = $urandom;
        for (int c = 0; c < 64 && !done; c++) begin
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            if (dmem_req) begin
                o.reqEver = 1'b1;
                if (o.reqCycles == 0) begin
                    o.be    = dmem_be;
                    o.wdata = dmem_wdata;
                    o.addr  = dmem_addr;
                    o.we    = dmem_we;
                end else if ({dmem_be, dmem_wdata, dmem_addr, dmem_we} !== {o.be, o.wdata, o.addr, o.we}) begin
                    o.held = 1'b0;
                end
                if (o.reqCycles == gntDelay) begin
                    dmem_gnt = 1'b1;
                    granted  = 1'b1;
                end
                o.reqCycles++;
            end else if (granted) begin
                if (waitCnt == rvDelay) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rdata;
                end
                waitCnt++;
            end
            @(negedge clk);
            if (ldst_stall) o.stallCycles++;
            else done = 1'b1;
            @(posedge clk); #1;
        end
        o.timedOut = !done;
        idleInputs();
        @(negedge clk);
        if (dmem_req) o.reqEver = 1'b1;
        o.regEn     = ldst_regfile_en;
        o.memtoreg  = ldst_memtoreg;
        o.dst       = ldst_addr_dst;
        o.memResult = ldst_mem_result;
        o.misalign  = ldst_misalign;
        if (!done) begin
            brq_rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 brq_rst = 1'b0;
        end
    endtask

    task automatic test_reset();
        idleInputs();
        brq_rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== 48'b0) begin
            failures++;
            $display("[TB] FAIL reset_dmem: got %h expected 0", {dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata});
        end
        checks++;
        if ({ldst_stall, ldst_regfile_en, ldst_memtoreg, ldst_addr_dst, ldst_mem_result, ldst_alu_result, ldst_misalign} !== 73'b0) begin
            failures++;
            $display("[TB] FAIL reset_ldst: got %h expected 0",
                     {ldst_stall, ldst_regfile_en, ldst_memtoreg, ldst_addr_dst, ldst_mem_result, ldst_alu_result, ldst_misalign});
        end
        @(posedge clk); #1;
        brq_rst = 1'b0;
    endtask

    task automatic test_lw();
        obs_t o;
        runOp(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd7, 0, 0, 32'hDEADBEEF, o);
        checks++;
        if (o.timedOut) begin failures++; $display("[TB] FAIL lw_timeout: stall never dropped"); end
        checks++;
        if (o.memResult !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL lw_result: got %h expected deadbeef", o.memResult); end
        checks++;
        if (o.regEn !== 1'b1 || o.dst !== 5'd7) begin failures++; $display("[TB] FAIL lw_wb: got en=%b dst=%0d expected en=1 dst=7", o.regEn, o.dst); end
        checks++;
        if (o.stallCycles != 2) begin failures++; $display("[TB] FAIL lw_stall: got %0d cycles expected 2", o.stallCycles); end
        checks++;
        if (o.addr !== 10'h040 || o.be !== 4'hF || o.we !== 1'b0) begin
            failures++; $display("[TB] FAIL lw_bus: got addr=%h be=%h we=%b expected addr=040 be=f we=0", o.addr, o.be, o.we);
        end
        @(negedge clk);
        checks++;
        if (ldst_regfile_en !== 1'b0) begin failures++; $display("[TB] FAIL lw_pulse_len: got en=%b expected 0", ldst_regfile_en); end
    endtask

    task automatic test_lb_lbu();
        obs_t o;
        runOp(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd3, 0, 1, 32'h80112233, o);
        checks++;
        if (o.timedOut || o.memResult !== 32'hFFFFFF80) begin
            failures++; $display("[TB] FAIL lb_result: got %h (timeout=%b) expected ffffff80", o.memResult, o.timedOut);
        end
        runOp(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd4, 1, 0, 32'h80112233, o);
        checks++;
        if (o.timedOut || o.memResult !== 32'h00000080) begin
            failures++; $display("[TB] FAIL lbu_result: got %h (timeout=%b) expected 00000080", o.memResult, o.timedOut);
        end
    endtask

    task automatic test_sh_delayed_gnt();
        obs_t o;
        runOp(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 5'd9, 3, 0, 32'h0, o);
        checks++;
        if (o.be !== 4'b1100 || o.wdata !== 32'hABCDABCD || o.we !== 1'b1) begin
            failures++; $display("[TB] FAIL sh_bus: got be=%b wdata=%h we=%b expected be=1100 wdata=abcdabcd we=1", o.be, o.wdata, o.we);
        end
        checks++;
        if (!o.held || o.reqCycles != 4) begin
            failures++; $display("[TB] FAIL sh_hold: got held=%b reqCycles=%0d expected held=1 reqCycles=4", o.held, o.reqCycles);
        end
        checks++;
        if (o.timedOut || o.stallCycles != 4) begin
            failures++; $display("[TB] FAIL sh_stall: got %0d cycles expected 4", o.stallCycles);
        end
        checks++;
        if (o.regEn !== 1'b0) begin failures++; $display("[TB] FAIL sh_regfile_en: got %b expected 0", o.regEn); end
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        ieu_mem_wen    = 1'b1;
        ieu_func3      = 3'b010;
        ieu_mem_addr   = 32'h300;
        ieu_store_data = $urandom;
        ieu_regfile_en = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (dmem_req !== 1'b1) begin failures++; $display("[TB] FAIL req_before_reset: got %b expected 1", dmem_req); end
        brq_rst = 1'b1;
        @(posedge clk); #1;
        brq_rst = 1'b0;
        idleInputs();
        checks++;
        if (dmem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_req: got req=%b expected 0", dmem_req); end

        @(posedge clk); #1;
        ieu_mem_ren    = 1'b1;
        ieu_func3      = 3'b010;
        ieu_mem_addr   = 32'h200;
        ieu_regfile_en = 1'b1;
        ieu_memtoreg   = 1'b1;
        ieu_addr_dst   = 5'd12;
        @(posedge clk); #1;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        brq_rst  = 1'b1;
        @(posedge clk); #1;
        brq_rst = 1'b0;
        idleInputs();
        @(negedge clk);
        checks++;
        if ({dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, ldst_stall, ldst_regfile_en, ldst_memtoreg,
             ldst_addr_dst, ldst_mem_result, ldst_alu_result, ldst_misalign} !== 121'b0) begin
            failures++; $display("[TB] FAIL reset_in_wait: outputs not all 0, stall=%b req=%b en=%b", ldst_stall, dmem_req, ldst_regfile_en);
        end
        @(posedge clk); #1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = $urandom | 32'h1;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (ldst_regfile_en !== 1'b0 || ldst_mem_result !== 32'h0) begin
            failures++; $display("[TB] FAIL stray_rvalid: got en=%b result=%h expected en=0 result=0", ldst_regfile_en, ldst_mem_result);
        end
    endtask

    task automatic test_misalign();
        obs_t o;
        runOp(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd5, 0, 0, 32'h13579BDF, o);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++;
        if (o.reqEver || o.stallCycles != 0 || o.regEn !== 1'b0) begin
            failures++; $display("[TB] FAIL misalign_no_req: got req=%b stall=%0d en=%b expected 0/0/0", o.reqEver, o.stallCycles, o.regEn);
        end
        checks++;
        if (o.misalign !== 1'b1) begin failures++; $display("[TB] FAIL misalign_flag: got %b expected 1", o.misalign); end
        @(negedge clk);
        checks++;
        if (ldst_misalign !== 1'b0) begin failures++; $display("[TB] FAIL misalign_pulse_len: got %b expected 0", ldst_misalign); end
`else
        checks++;
        if (o.addr !== 10'h040 || o.be !== 4'hF) begin
            failures++; $display("[TB] FAIL misalign_aligned_down: got addr=%h be=%h expected addr=040 be=f", o.addr, o.be);
        end
        checks++;
        if (o.timedOut || o.memResult !== 32'h13579BDF || o.misalign !== 1'b0) begin
            failures++; $display("[TB] FAIL misalign_result: got %h flag=%b expected 13579bdf flag=0", o.memResult, o.misalign);
        end
`endif
    endtask

    task automatic test_passthrough();
        logic        en, m2r;
        logic [4:0]  dst;
        logic [31:0] alu;
        for (int i = 0; i < 6; i++) begin
            en  = 1'($urandom);
            m2r = 1'($urandom);
            dst = 5'($urandom);
            alu = $urandom;
            @(posedge clk); #1;
            idleInputs();
            ieu_regfile_en       = en;
            ieu_memtoreg         = m2r;
            ieu_addr_dst         = dst;
            ieu_alu_result_dealy = alu;
            @(negedge clk);
            checks++;
            if (ldst_stall !== 1'b0) begin failures++; $display("[TB] FAIL pass_stall: got %b expected 0", ldst_stall); end
            @(posedge clk); #1;
            checks++;
            if ({ldst_regfile_en, ldst_memtoreg, ldst_addr_dst, ldst_alu_result} !== {en, m2r, dst, alu}) begin
                failures++; $display("[TB] FAIL pass_regs: got %h expected %h",
                                     {ldst_regfile_en, ldst_memtoreg, ldst_addr_dst, ldst_alu_result}, {en, m2r, dst, alu});
            end
        end
        idleInputs();
    endtask

    task automatic test_random_ops();
        logic [2:0]  loadF3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        obs_t        o;
        logic        ren, wen;
        logic [2:0]  f3;
        logic [31:0] addr, sdata, rdata;
        int          gd, rd, sz;
        for (int i = 0; i < 40; i++) begin
            ren = 1'($urandom);
            wen = !ren || ($urandom_range(0, 3) == 0);
            f3  = ren ? loadF3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            addr  = $urandom;
            sz    = sizeOf(f3);
`ifdef LSU_MISALIGN_TRAP_EN
            addr = addr - (addr % sz);
`endif
            sdata = $urandom;
            rdata = $urandom;
            gd    = $urandom_range(0, 3);
            rd    = $urandom_range(0, 3);
            runOp(ren, wen, f3, addr, sdata, 5'($urandom), gd, rd, rdata, o);
            checks++;
            if (o.timedOut || o.addr !== 10'(addr / 4) || o.we !== !ren || !o.held) begin
                failures++; $display("[TB] FAIL rand_bus op%0d: got addr=%h we=%b held=%b to=%b expected addr=%h we=%b",
                                     i, o.addr, o.we, o.held, o.timedOut, 10'(addr / 4), !ren);
            end
            checks++;
            if (o.stallCycles != (ren ? gd + rd + 2 : gd + 1)) begin
                failures++; $display("[TB] FAIL rand_stall op%0d: got %0d expected %0d", i, o.stallCycles, ren ? gd + rd + 2 : gd + 1);
            end
            checks++;
            if (ren) begin
                if (o.memResult !== expLoad(f3, addr, rdata) || o.regEn !== 1'b1 || o.memtoreg !== 1'b1) begin
                    failures++; $display("[TB] FAIL rand_load op%0d f3=%0d addr=%h: got %h en=%b expected %h en=1",
                                         i, f3, addr, o.memResult, o.regEn, expLoad(f3, addr, rdata));
                end
            end else begin
                if (o.be !== expBe(f3, addr) || o.wdata !== expWdata(f3, sdata) || o.regEn !== 1'b0) begin
                    failures++; $display("[TB] FAIL rand_store op%0d f3=%0d addr=%h: got be=%b wdata=%h en=%b expected be=%b wdata=%h en=0",
                                         i, f3, addr, o.be, o.wdata, o.regEn, expBe(f3, addr), expWdata(f3, sdata));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        runOp(1'b0, 1'b1, 3'b000, 32'h0000_0041, 32'h0000_005A, 5'd1, 0, 0, 32'h0, o);
        checks++;
        if (o.timedOut || o.stallCycles != 1 || o.be !== 4'b0010 || o.wdata !== 32'h5A5A5A5A) begin
            failures++; $display("[TB] FAIL b2b_sb: got stall=%0d be=%b wdata=%h expected stall=1 be=0010 wdata=5a5a5a5a",
                                 o.stallCycles, o.be, o.wdata);
        end
        runOp(1'b1, 1'b1, 3'b101, 32'h0000_0042, 32'hFFFF_FFFF, 5'd2, 0, 0, 32'hC3A5_1234, o);
        checks++;
        if (o.timedOut || o.we !== 1'b0 || o.stallCycles != 2 || o.memResult !== 32'h0000_C3A5) begin
            failures++; $display("[TB] FAIL b2b_load_wins: got we=%b stall=%0d result=%h expected we=0 stall=2 result=0000c3a5",
                                 o.we, o.stallCycles, o.memResult);
        end
    endtask

    initial begin
        dmem_rdata = '0;
        test_reset();
        test_lw();
        test_lb_lbu();
        test_sh_delayed_gnt();
        test_reset_mid_access();
        test_misalign();
        test_passthrough();
        test_back_to_back();
        test_random_ops();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
